// File: rtl/rx_ctrl.sv
// rx_ctrl: USRT receive sequencer. It deserialises frames and drives the Rx data register push/pop strobes.
// Optional parity stage is compiled in with `define USRT_RX_PARITY_EN.
module rx_ctrl #(
    parameter int DATA_BITS  = 8,
    parameter int LSB_FIRST  = 1,
    parameter int ODD_PARITY = 0
) (
    input  logic       i_Pclk,
    input  logic       i_Reset,
    input  logic       i_Enable,
    input  logic       i_SclkRise,
    input  logic       i_RxBit,
    input  logic       i_Full,
    input  logic       i_Read,
    input  logic       i_ClrErr,
    output logic [7:0] o_Data,
    output logic       o_Push,
    output logic       o_Pop,
    output logic       o_Overrun,
    output logic       o_FrameErr,
    output logic       o_ParityErr,
    output logic       o_Busy,
    output logic       o_Irq
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_DELIVER
    } state_t;

    localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

    if (DATA_BITS < 5 || DATA_BITS > 8 || LSB_FIRST > 1 || ODD_PARITY > 1) begin : g_bad_params
        $error("rx_ctrl: illegal parameter value");
    end

    state_t                 state_q, state_d;
    logic [2:0]             bit_cnt_q, bit_cnt_d;
    logic [DATA_BITS-1:0]   shift_q, shift_d;
    logic [7:0]             data_d;
    logic                   overrun_set;
    logic                   frame_err_set;

`ifdef USRT_RX_PARITY_EN
    logic                   par_bad_q, par_bad_d;
    logic                   parity_err_set;
    logic                   parity_mismatch;

    // Data ones plus received parity bit must match the configured sense.
    assign parity_mismatch = ((^shift_q) ^ i_RxBit) != ODD_PARITY[0];
`endif

    // NOTE: every variable written here gets a default first, so no path can infer a latch.
    always_comb begin
        state_d       = state_q;
        bit_cnt_d     = bit_cnt_q;
        shift_d       = shift_q;
        data_d        = o_Data;
        overrun_set   = 1'b0;
        frame_err_set = 1'b0;
        o_Push        = 1'b0;
        o_Pop         = i_Read & i_Full;
`ifdef USRT_RX_PARITY_EN
        par_bad_d      = par_bad_q;
        parity_err_set = 1'b0;
`endif

        if (!i_Enable && state_q != S_DELIVER) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (i_SclkRise && !i_RxBit) begin
                        state_d   = S_DATA;
                        bit_cnt_d = 3'd0;
                        shift_d   = '0;
`ifdef USRT_RX_PARITY_EN
                        par_bad_d = 1'b0;
`endif
                    end
                end

                S_DATA: begin
                    if (i_SclkRise) begin
                        if (LSB_FIRST != 0) begin
                            shift_d = {i_RxBit, shift_q[DATA_BITS-1:1]};
                        end else begin
                            shift_d = {shift_q[DATA_BITS-2:0], i_RxBit};
                        end
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == LAST_BIT) begin
`ifdef USRT_RX_PARITY_EN
                            state_d = S_PARITY;
`else
                            state_d = S_STOP;
`endif
                        end
                    end
                end

`ifdef USRT_RX_PARITY_EN
                S_PARITY: begin
                    if (i_SclkRise) begin
                        if (parity_mismatch) begin
                            parity_err_set = 1'b1;
                            par_bad_d      = 1'b1;
                        end
                        state_d = S_STOP;
                    end
                end
`endif

                S_STOP: begin
                    if (i_SclkRise) begin
                        if (i_RxBit) begin
                            state_d = S_DELIVER;
                            data_d  = 8'(shift_q);
                        end else begin
                            frame_err_set = 1'b1;
                            state_d       = S_IDLE;
                        end
                    end
                end

                S_DELIVER: begin
                    // A pending CPU pop frees the register first; the push follows next cycle.
                    if (i_Read && i_Full) begin
                        state_d = S_DELIVER;
`ifdef USRT_RX_PARITY_EN
                    end else if (par_bad_q) begin
                        state_d = S_IDLE;
`endif
                    end else if (!i_Full) begin
                        o_Push  = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        overrun_set = 1'b1;
                        state_d     = S_IDLE;
                    end
                end

                default: state_d = S_IDLE;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge i_Pclk or posedge i_Reset) begin
        if (i_Reset) begin
            state_q    <= S_IDLE;
            bit_cnt_q  <= 3'd0;
            shift_q    <= '0;
            o_Data     <= 8'h00;
            o_Overrun  <= 1'b0;
            o_FrameErr <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            o_Data     <= data_d;
            o_Overrun  <= overrun_set   | (o_Overrun  & ~i_ClrErr);
            o_FrameErr <= frame_err_set | (o_FrameErr & ~i_ClrErr);
        end
    end

`ifdef USRT_RX_PARITY_EN
    always_ff @(posedge i_Pclk or posedge i_Reset) begin
        if (i_Reset) begin
            par_bad_q   <= 1'b0;
            o_ParityErr <= 1'b0;
        end else begin
            par_bad_q   <= par_bad_d;
            o_ParityErr <= parity_err_set | (o_ParityErr & ~i_ClrErr);
        end
    end
`else
    assign o_ParityErr = 1'b0;
`endif

    assign o_Busy = (state_q != S_IDLE);
    assign o_Irq  = i_Full | o_Overrun | o_FrameErr | o_ParityErr;

endmodule

// File: tb/tb_rx_ctrl.sv
// tb_rx_ctrl: directed self-checking bench for rx_ctrl (default parameters).
// Parity scenarios are exercised when USRT_RX_PARITY_EN is defined.
module tb_rx_ctrl;

    logic       i_Pclk = 1'b0;
    logic       i_Reset;
    logic       i_Enable;
    logic       i_SclkRise;
    logic       i_RxBit;
    logic       i_Full;
    logic       i_Read;
    logic       i_ClrErr;
    logic [7:0] o_Data;
    logic       o_Push;
    logic       o_Pop;
    logic       o_Overrun;
    logic       o_FrameErr;
    logic       o_ParityErr;
    logic       o_Busy;
    logic       o_Irq;

    int checks = 0;
    int errors = 0;

`ifdef USRT_RX_PARITY_EN
    logic par_flip = 1'b0;
`endif

    rx_ctrl dut (
        .i_Pclk     (i_Pclk),
        .i_Reset    (i_Reset),
        .i_Enable   (i_Enable),
        .i_SclkRise (i_SclkRise),
        .i_RxBit    (i_RxBit),
        .i_Full     (i_Full),
        .i_Read     (i_Read),
        .i_ClrErr   (i_ClrErr),
        .o_Data     (o_Data),
        .o_Push     (o_Push),
        .o_Pop      (o_Pop),
        .o_Overrun  (o_Overrun),
        .o_FrameErr (o_FrameErr),
        .o_ParityErr(o_ParityErr),
        .o_Busy     (o_Busy),
        .o_Irq      (o_Irq)
    );

    always #5 i_Pclk = ~i_Pclk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got running exp finished");
        $fatal(1, "watchdog");
    end

    // Called at a falling edge; presents one sample for the next rising edge.
    task automatic sample(input logic b);
        i_SclkRise = 1'b1;
        i_RxBit    = b;
        @(negedge i_Pclk);
        i_SclkRise = 1'b0;
        i_RxBit    = 1'b1;
    endtask

    // Start bit, 8 data bits LSB first, optional parity, stop bit. Returns in the cycle after the stop sample.
    task automatic send_frame(input logic [7:0] d, input logic stop_b);
        sample(1'b0);
        for (int i = 0; i < 8; i++) sample(d[i]);
`ifdef USRT_RX_PARITY_EN
        sample((^d) ^ par_flip);
`endif
        sample(stop_b);
    endtask

    task automatic pulse_clr();
        i_ClrErr = 1'b1;
        @(negedge i_Pclk);
        i_ClrErr = 1'b0;
    endtask

    task automatic test_reset();
        i_Reset = 1'b1; i_Enable = 1'b1; i_SclkRise = 1'b0; i_RxBit = 1'b1;
        i_Full = 1'b0; i_Read = 1'b0; i_ClrErr = 1'b0;
        repeat (2) @(negedge i_Pclk);
        checks++; if (o_Data !== 8'h00) begin errors++; $display("FAIL reset_data: got %h exp 00", o_Data); end
        checks++; if (o_Busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b exp 0", o_Busy); end
        checks++; if ({o_Push, o_Pop} !== 2'b00) begin errors++; $display("FAIL reset_strobes: got %b exp 00", {o_Push, o_Pop}); end
        checks++; if ({o_Overrun, o_FrameErr, o_ParityErr, o_Irq} !== 4'b0000) begin
            errors++; $display("FAIL reset_flags: got %b exp 0000", {o_Overrun, o_FrameErr, o_ParityErr, o_Irq}); end
        i_Reset = 1'b0;
        @(negedge i_Pclk);
        checks++; if (o_Busy !== 1'b0) begin errors++; $display("FAIL post_reset_busy: got %b exp 0", o_Busy); end
    endtask

    task automatic test_push();
        send_frame(8'h4D, 1'b1);
        checks++; if (o_Push !== 1'b1) begin errors++; $display("FAIL push_strobe: got %b exp 1", o_Push); end
        checks++; if (o_Data !== 8'h4D) begin errors++; $display("FAIL push_data: got %h exp 4d", o_Data); end
        checks++; if (o_Irq !== 1'b0) begin errors++; $display("FAIL push_irq: got %b exp 0", o_Irq); end
        checks++; if (o_Pop !== 1'b0) begin errors++; $display("FAIL push_pop: got %b exp 0", o_Pop); end
        checks++; if (o_Busy !== 1'b1) begin errors++; $display("FAIL deliver_busy: got %b exp 1", o_Busy); end
        @(negedge i_Pclk);
        checks++; if (o_Push !== 1'b0) begin errors++; $display("FAIL push_single: got %b exp 0", o_Push); end
        checks++; if (o_Busy !== 1'b0) begin errors++; $display("FAIL push_idle: got %b exp 0", o_Busy); end
        i_Full = 1'b1;
        #1;
        checks++; if (o_Irq !== 1'b1) begin errors++; $display("FAIL full_irq: got %b exp 1", o_Irq); end
        i_Full = 1'b0;
    endtask

    task automatic test_overrun();
        i_Full = 1'b1;
        send_frame(8'h4D, 1'b1);
        checks++; if ({o_Push, o_Pop} !== 2'b00) begin errors++; $display("FAIL ovr_strobes: got %b exp 00", {o_Push, o_Pop}); end
        @(negedge i_Pclk);
        checks++; if (o_Overrun !== 1'b1) begin errors++; $display("FAIL ovr_flag: got %b exp 1", o_Overrun); end
        checks++; if (o_Irq !== 1'b1) begin errors++; $display("FAIL ovr_irq: got %b exp 1", o_Irq); end
        checks++; if (o_Busy !== 1'b0) begin errors++; $display("FAIL ovr_idle: got %b exp 0", o_Busy); end
        pulse_clr();
        checks++; if (o_Overrun !== 1'b0) begin errors++; $display("FAIL ovr_clear: got %b exp 0", o_Overrun); end
        i_Full = 1'b0;
        #1;
        checks++; if (o_Irq !== 1'b0) begin errors++; $display("FAIL ovr_irq_clear: got %b exp 0", o_Irq); end
    endtask

    task automatic test_set_beats_clear();
        i_Full = 1'b1;
        send_frame(8'h12, 1'b1);
        i_ClrErr = 1'b1;
        @(negedge i_Pclk);
        checks++; if (o_Overrun !== 1'b1) begin errors++; $display("FAIL set_vs_clr: got %b exp 1", o_Overrun); end
        @(negedge i_Pclk);
        i_ClrErr = 1'b0;
        checks++; if (o_Overrun !== 1'b0) begin errors++; $display("FAIL clr_after_set: got %b exp 0", o_Overrun); end
        i_Full = 1'b0;
    endtask

    task automatic test_frame_err();
        send_frame(8'h55, 1'b0);
        checks++; if (o_Push !== 1'b0) begin errors++; $display("FAIL ferr_push: got %b exp 0", o_Push); end
        checks++; if (o_FrameErr !== 1'b1) begin errors++; $display("FAIL ferr_flag: got %b exp 1", o_FrameErr); end
        checks++; if (o_Busy !== 1'b0) begin errors++; $display("FAIL ferr_idle: got %b exp 0", o_Busy); end
        @(negedge i_Pclk);
        send_frame(8'hA3, 1'b1);
        checks++; if (o_Push !== 1'b1) begin errors++; $display("FAIL a3_push: got %b exp 1", o_Push); end
        checks++; if (o_Data !== 8'hA3) begin errors++; $display("FAIL a3_data: got %h exp a3", o_Data); end
        @(negedge i_Pclk);
        checks++; if (o_FrameErr !== 1'b1) begin errors++; $display("FAIL ferr_sticky: got %b exp 1", o_FrameErr); end
        pulse_clr();
        checks++; if (o_FrameErr !== 1'b0) begin errors++; $display("FAIL ferr_clear: got %b exp 0", o_FrameErr); end
    endtask

    task automatic test_pop_priority();
        i_Full = 1'b1;
        send_frame(8'h3C, 1'b1);
        i_Read = 1'b1;
        #1;
        checks++; if ({o_Pop, o_Push} !== 2'b10) begin errors++; $display("FAIL pop_first: got pop/push %b exp 10", {o_Pop, o_Push}); end
        @(negedge i_Pclk);
        i_Read = 1'b0;
        i_Full = 1'b0;
        #1;
        checks++; if ({o_Pop, o_Push} !== 2'b01) begin errors++; $display("FAIL push_after_pop: got pop/push %b exp 01", {o_Pop, o_Push}); end
        checks++; if (o_Data !== 8'h3C) begin errors++; $display("FAIL pop_data: got %h exp 3c", o_Data); end
        @(negedge i_Pclk);
        checks++; if ({o_Push, o_Busy, o_Overrun} !== 3'b000) begin
            errors++; $display("FAIL pop_done: got push/busy/ovr %b exp 000", {o_Push, o_Busy, o_Overrun}); end
        i_Read = 1'b1;
        #1;
        checks++; if (o_Pop !== 1'b0) begin errors++; $display("FAIL read_empty: got %b exp 0", o_Pop); end
        i_Full = 1'b1;
        #1;
        checks++; if (o_Pop !== 1'b1) begin errors++; $display("FAIL read_full: got %b exp 1", o_Pop); end
        i_Read = 1'b0;
        i_Full = 1'b0;
    endtask

    task automatic test_back_to_back();
        send_frame(8'h81, 1'b1);
        checks++; if (o_Push !== 1'b1 || o_Data !== 8'h81) begin
            errors++; $display("FAIL b2b_first: got push %b data %h exp 1 81", o_Push, o_Data); end
        @(negedge i_Pclk);
        send_frame(8'h7E, 1'b1);
        checks++; if (o_Push !== 1'b1 || o_Data !== 8'h7E) begin
            errors++; $display("FAIL b2b_second: got push %b data %h exp 1 7e", o_Push, o_Data); end
        @(negedge i_Pclk);
    endtask

    task automatic test_enable_drop();
        sample(1'b0);
        sample(1'b1); sample(1'b0); sample(1'b1); sample(1'b1);
        checks++; if (o_Busy !== 1'b1) begin errors++; $display("FAIL en_busy: got %b exp 1", o_Busy); end
        i_Enable = 1'b0;
        @(negedge i_Pclk);
        checks++; if (o_Busy !== 1'b0) begin errors++; $display("FAIL en_drop_idle: got %b exp 0", o_Busy); end
        checks++; if ({o_Push, o_FrameErr, o_Overrun} !== 3'b000) begin
            errors++; $display("FAIL en_drop_quiet: got push/ferr/ovr %b exp 000", {o_Push, o_FrameErr, o_Overrun}); end
        checks++; if (o_Data !== 8'h7E) begin errors++; $display("FAIL en_drop_data: got %h exp 7e", o_Data); end
        sample(1'b0);
        checks++; if (o_Busy !== 1'b0) begin errors++; $display("FAIL en_low_start: got %b exp 0", o_Busy); end
        i_Enable = 1'b1;
        @(negedge i_Pclk);
    endtask

    task automatic test_reset_midframe();
        send_frame(8'h00, 1'b0);
        @(negedge i_Pclk);
        sample(1'b0); sample(1'b1); sample(1'b1);
        checks++; if (o_Busy !== 1'b1 || o_FrameErr !== 1'b1) begin
            errors++; $display("FAIL pre_reset: got busy %b ferr %b exp 1 1", o_Busy, o_FrameErr); end
        #2;
        i_Reset = 1'b1;
        #1;
        checks++; if (o_Busy !== 1'b0 || o_Data !== 8'h00) begin
            errors++; $display("FAIL async_reset: got busy %b data %h exp 0 00", o_Busy, o_Data); end
        checks++; if ({o_FrameErr, o_Overrun, o_ParityErr, o_Push, o_Pop} !== 5'b00000) begin
            errors++; $display("FAIL async_reset_flags: got %b exp 00000", {o_FrameErr, o_Overrun, o_ParityErr, o_Push, o_Pop}); end
        @(negedge i_Pclk);
        i_Reset = 1'b0;
        @(negedge i_Pclk);
        send_frame(8'hC5, 1'b1);
        checks++; if (o_Push !== 1'b1 || o_Data !== 8'hC5) begin
            errors++; $display("FAIL post_reset_frame: got push %b data %h exp 1 c5", o_Push, o_Data); end
        @(negedge i_Pclk);
    endtask

    task automatic test_parity();
`ifdef USRT_RX_PARITY_EN
        par_flip = 1'b1;
        send_frame(8'h07, 1'b1);
        checks++; if (o_Push !== 1'b0) begin errors++; $display("FAIL par_bad_push: got %b exp 0", o_Push); end
        checks++; if (o_ParityErr !== 1'b1) begin errors++; $display("FAIL par_bad_flag: got %b exp 1", o_ParityErr); end
        @(negedge i_Pclk);
        pulse_clr();
        par_flip = 1'b0;
        send_frame(8'h07, 1'b1);
        checks++; if (o_Push !== 1'b1 || o_Data !== 8'h07) begin
            errors++; $display("FAIL par_good: got push %b data %h exp 1 07", o_Push, o_Data); end
        checks++; if (o_ParityErr !== 1'b0) begin errors++; $display("FAIL par_good_flag: got %b exp 0", o_ParityErr); end
        @(negedge i_Pclk);
`else
        send_frame(8'h07, 1'b1);
        checks++; if (o_Push !== 1'b1 || o_ParityErr !== 1'b0) begin
            errors++; $display("FAIL no_parity: got push %b perr %b exp 1 0", o_Push, o_ParityErr); end
        @(negedge i_Pclk);
`endif
    endtask

    initial begin
        test_reset();
        test_push();
        test_overrun();
        test_set_beats_clear();
        test_frame_err();
        test_pop_priority();
        test_back_to_back();
        test_enable_drop();
        test_parity();
        test_reset_midframe();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rx_ctrl.md
Name: rx_ctrl

Overview:
Receive-path sequencer for the USRT.
- Deserialises frames from the sampled serial line.
- Drives the push/pop strobes of the 8-bit Rx data register.
- Arbitrates CPU reads against new-frame delivery and maintains sticky overrun and frame-error status plus an interrupt.
- Sits between the USRT clock-edge detector and the Rx data register, all in the i_Pclk domain.

Parameters:
DATA_BITS, 8, data bits per frame (5..8); o_Data upper unused bits are 0.
LSB_FIRST, 1, 1 = first received data bit lands in o_Data[0]; 0 = first bit lands in o_Data[DATA_BITS-1].
ODD_PARITY, 0, parity sense when USRT_RX_PARITY_EN is defined (0 = even, 1 = odd).

Ports:
i_Pclk  in  1  system clock, all logic on rising edge.
i_Reset  in  1  asynchronous, active-high reset.
i_Enable  in  1  receiver enable.
i_SclkRise  in  1  one-cycle pulse marking the serial sample point.
i_RxBit  in  1  serial data, valid when i_SclkRise=1.
i_Full  in  1  Rx data register full flag.
i_Read  in  1  CPU read strobe of the Rx data register.
i_ClrErr  in  1  clear sticky error flags.
o_Data  out  8  assembled frame to the data register.
o_Push  out  1  write strobe to the data register.
o_Pop  out  1  pop strobe to the data register.
o_Overrun  out  1  sticky: frame dropped because the register was full.
o_FrameErr  out  1  sticky: stop bit sampled 0.
o_ParityErr  out  1  sticky: parity mismatch.
o_Busy  out  1  high in any state other than IDLE.
o_Irq  out  1  i_Full | o_Overrun | o_FrameErr | o_ParityErr.

Behaviour:
- Reset (asynchronous):
  - state = IDLE; bit counter = 0; shift register = 0.
  - o_Data = 0; o_Overrun = o_FrameErr = o_ParityErr = 0.
  - o_Push = o_Pop = o_Busy = 0.
  - Reset mid-frame discards the partial frame.
- FSM states: IDLE, DATA, PARITY (feature only), STOP, DELIVER.
- State actions are taken only on cycles with i_SclkRise=1, except in DELIVER.
- IDLE:
  - i_Enable=1 and sample=0 (start bit) -> DATA; bit counter cleared.
  - sample=1 -> stay in IDLE.
- DATA:
  - Each sample is shifted in per LSB_FIRST; the counter increments.
  - After the DATA_BITS-th sample -> PARITY if compiled in, else STOP.
- STOP:
  - Sample=1 -> DELIVER, and o_Data loads the assembled byte.
  - Sample=0 -> o_FrameErr set, -> IDLE, no push.
- DELIVER (no sample required):
  - i_Read=1 and i_Full=1: o_Pop=1, o_Push=0, stay in DELIVER one cycle (pop takes priority; push is deferred).
  - Else i_Full=0: o_Push=1 -> IDLE.
  - Else (i_Full=1, no read): o_Overrun set, frame dropped, o_Push=0 -> IDLE.
- Latency: stop-bit sample in cycle N -> o_Push in cycle N+1 if the register is empty.
- o_Push and o_Pop are combinational decodes of state and inputs. They are never high in the same cycle.
- Outside DELIVER, o_Pop = i_Read & i_Full. i_Read with i_Full=0 is ignored.
- i_Enable dropped in any state other than DELIVER:
  - -> IDLE next cycle.
  - No push and no error flag.
  - o_Data keeps its last value.
- Sticky flags:
  - Set by their events; cleared by i_ClrErr.
  - A set event and i_ClrErr in the same cycle -> the flag ends set.
- Back-to-back frames: a new start bit is accepted on the first sample after returning to IDLE.

Optional Feature:
USRT_RX_PARITY_EN
- Defined:
  - PARITY state follows DATA and samples one parity bit.
  - Mismatch against even/odd per ODD_PARITY sets o_ParityErr, and the frame is dropped at DELIVER (no push). Then -> STOP as usual.
- Undefined:
  - No PARITY state; DATA -> STOP directly.
  - o_ParityErr is tied to 0.

Test Plan:
- Reset, then frame 0,1,0,1,1,0,0,1,0,1 (start, 8 data LSB-first, stop) with i_Full=0 -> o_Push one cycle after the stop sample, o_Data=8'h4D, o_Irq=0 (until i_Full rises).
- Same frame with i_Full=1 and no read -> o_Push=0, o_Overrun=1, o_Irq=1; then i_ClrErr=1 -> o_Overrun=0.
- Frame 0x55 with stop bit 0 -> o_FrameErr=1, no o_Push, state returns to IDLE; a following valid frame 0xA3 pushes 0xA3.
- i_Full=1 and i_Read=1 in the DELIVER cycle -> o_Pop cycle N, o_Push cycle N+1 with the new byte, never both high.
- i_Enable deasserted after 4 data bits -> o_Busy=0 next cycle, no push, no error; i_Reset asserted mid-frame asynchronously clears all outputs.
- USRT_RX_PARITY_EN with ODD_PARITY=0, data 0x07 and parity bit 0 -> o_ParityErr=1, no push; with parity bit 1 -> push 0x07.
